// File: rtl/reservation_station_pkg.sv
// Shared definitions for the reservation station slice: ROB tag width,
// ALU op encodings, the reserved "value present" tag and index-width helper.
package reservation_station_pkg;

    localparam int ROB_ENTRY_WIDTH = 4;
    localparam int RS_DATA_W       = 32;

    localparam logic [ROB_ENTRY_WIDTH-1:0] RS_TAG_NONE = '0;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    function automatic int rs_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reservation_station_if.sv
// Dispatch, CDB snoop and issue signals of the reservation station.
// Handshakes: a transfer happens on a rising edge where valid && ready;
// valid never waits on ready, and the payload is meaningful only with valid.
interface reservation_station_if
    import reservation_station_pkg::*;
#(
    parameter int ROB_W = ROB_ENTRY_WIDTH,
    parameter int OP_W  = 4
) ();

    logic                 disp_valid;
    logic                 disp_ready;
    logic [OP_W-1:0]      disp_op;
    logic [RS_DATA_W-1:0] disp_a_value;
    logic [ROB_W-1:0]     disp_a_tag;
    logic [RS_DATA_W-1:0] disp_b_value;
    logic [ROB_W-1:0]     disp_b_tag;
    logic [ROB_W-1:0]     disp_dest;

    logic                 cdb_valid;
    logic [ROB_W-1:0]     cdb_tag;
    logic [RS_DATA_W-1:0] cdb_value;

    logic                 issue_valid;
    logic                 issue_ready;
    logic [OP_W-1:0]      issue_op;
    logic [RS_DATA_W-1:0] issue_a;
    logic [RS_DATA_W-1:0] issue_b;
    logic [ROB_W-1:0]     issue_dest;

    modport master (
        output disp_valid, disp_op, disp_a_value, disp_a_tag,
               disp_b_value, disp_b_tag, disp_dest,
               cdb_valid, cdb_tag, cdb_value, issue_ready,
        input  disp_ready, issue_valid, issue_op, issue_a, issue_b, issue_dest
    );

    modport slave (
        input  disp_valid, disp_op, disp_a_value, disp_a_tag,
               disp_b_value, disp_b_tag, disp_dest,
               cdb_valid, cdb_tag, cdb_value, issue_ready,
        output disp_ready, issue_valid, issue_op, issue_a, issue_b, issue_dest
    );

endinterface

// File: rtl/reservation_station_prio_enc.sv
// Lowest-set-bit priority encoder with an any-bit-set flag.
module rs_priority_encoder
    import reservation_station_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = rs_idx_w(N)
) (
    input  logic [N-1:0]     bits,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        idx = '0;
        any = |bits;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (bits[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Tomasulo reservation station: buffers dispatched ops, wakes pending
// operands from the CDB and issues the lowest-index ready entry.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ROB_W = ROB_ENTRY_WIDTH,
    parameter int OP_W  = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    input logic                  flush,
    reservation_station_if.slave rs
);

    localparam int IDX_W = rs_idx_w(DEPTH);
    localparam logic [ROB_W-1:0] TAG_NONE = ROB_W'(RS_TAG_NONE);

    logic [DEPTH-1:0]     busy;
    logic [OP_W-1:0]      op_q    [DEPTH];
    logic [ROB_W-1:0]     a_tag_q [DEPTH];
    logic [RS_DATA_W-1:0] a_val_q [DEPTH];
    logic [ROB_W-1:0]     b_tag_q [DEPTH];
    logic [RS_DATA_W-1:0] b_val_q [DEPTH];
    logic [ROB_W-1:0]     dest_q  [DEPTH];

    logic [DEPTH-1:0] free_vec;
    logic [DEPTH-1:0] rdy_vec;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] rdy_idx;
    logic             free_any;
    logic             rdy_any;
    logic             disp_fire;
    logic             issue_fire;
    logic             disp_a_hit;
    logic             disp_b_hit;

    assign free_vec = ~busy;

    always_comb begin
        rdy_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rdy_vec[i] = busy[i] && (a_tag_q[i] == TAG_NONE) && (b_tag_q[i] == TAG_NONE);
        end
    end

    rs_priority_encoder #(.N(DEPTH), .IDX_W(IDX_W)) u_free_enc (
        .bits (free_vec),
        .idx  (free_idx),
        .any  (free_any)
    );

    rs_priority_encoder #(.N(DEPTH), .IDX_W(IDX_W)) u_ready_enc (
        .bits (rdy_vec),
        .idx  (rdy_idx),
        .any  (rdy_any)
    );

    // Both flags come from registered state only, so a slot freed by issue
    // this cycle is not offered to dispatch until the next one.
    assign rs.disp_ready  = free_any;
    assign rs.issue_valid = rdy_any;

    assign disp_fire  = rs.disp_valid && free_any;
    assign issue_fire = rdy_any && rs.issue_ready;

    assign disp_a_hit = rs.cdb_valid && (rs.disp_a_tag != TAG_NONE) && (rs.disp_a_tag == rs.cdb_tag);
    assign disp_b_hit = rs.cdb_valid && (rs.disp_b_tag != TAG_NONE) && (rs.disp_b_tag == rs.cdb_tag);

    always_comb begin
        rs.issue_op   = '0;
        rs.issue_a    = '0;
        rs.issue_b    = '0;
        rs.issue_dest = '0;
        if (rdy_any) begin
            rs.issue_op   = op_q[rdy_idx];
            rs.issue_a    = a_val_q[rdy_idx];
            rs.issue_b    = b_val_q[rdy_idx];
            rs.issue_dest = dest_q[rdy_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]    <= '0;
                a_tag_q[i] <= '0;
                a_val_q[i] <= '0;
                b_tag_q[i] <= '0;
                b_val_q[i] <= '0;
                dest_q[i]  <= '0;
            end
        end else if (flush) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy[i] && rs.cdb_valid && (a_tag_q[i] != TAG_NONE) && (a_tag_q[i] == rs.cdb_tag)) begin
                    a_tag_q[i] <= TAG_NONE;
                    a_val_q[i] <= rs.cdb_value;
                end
                if (busy[i] && rs.cdb_valid && (b_tag_q[i] != TAG_NONE) && (b_tag_q[i] == rs.cdb_tag)) begin
                    b_tag_q[i] <= TAG_NONE;
                    b_val_q[i] <= rs.cdb_value;
                end
                if (issue_fire && (rdy_idx == IDX_W'(i))) begin
                    busy[i] <= 1'b0;
                end
                // The allocated slot is never busy, so this cannot collide
                // with the wake-up or issue updates above.
                if (disp_fire && (free_idx == IDX_W'(i))) begin
                    busy[i]    <= 1'b1;
                    op_q[i]    <= rs.disp_op;
                    dest_q[i]  <= rs.disp_dest;
                    a_tag_q[i] <= disp_a_hit ? TAG_NONE : rs.disp_a_tag;
                    a_val_q[i] <= disp_a_hit ? rs.cdb_value : rs.disp_a_value;
                    b_tag_q[i] <= disp_b_hit ? TAG_NONE : rs.disp_b_tag;
                    b_val_q[i] <= disp_b_hit ? rs.cdb_value : rs.disp_b_value;
                end
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: dispatch, CDB wake-up, bypass,
// full/ordering, stall stability, flush and asynchronous reset.
module tb_reservation_station;
    import reservation_station_pkg::*;

    logic clk;
    logic rst_n;
    logic flush;
    int   tests_run;
    int   tests_failed;

    reservation_station_if #(.ROB_W(4), .OP_W(4)) bus ();

    reservation_station #(.DEPTH(4), .ROB_W(4), .OP_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .rs    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic set_disp(input logic [3:0] op, input logic [31:0] a, input logic [3:0] at,
                            input logic [31:0] b, input logic [3:0] bt, input logic [3:0] dest);
        bus.disp_valid   = 1'b1;
        bus.disp_op      = op;
        bus.disp_a_value = a;
        bus.disp_a_tag   = at;
        bus.disp_b_value = b;
        bus.disp_b_tag   = bt;
        bus.disp_dest    = dest;
    endtask

    task automatic set_cdb(input logic v, input logic [3:0] tag, input logic [31:0] value);
        bus.cdb_valid = v;
        bus.cdb_tag   = tag;
        bus.cdb_value = value;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        flush        = 1'b0;
        bus.disp_valid   = 1'b0;
        bus.disp_op      = '0;
        bus.disp_a_value = '0;
        bus.disp_a_tag   = '0;
        bus.disp_b_value = '0;
        bus.disp_b_tag   = '0;
        bus.disp_dest    = '0;
        bus.cdb_valid    = 1'b0;
        bus.cdb_tag      = '0;
        bus.cdb_value    = '0;
        bus.issue_ready  = 1'b0;

        #3;
        check("rst_disp_ready", 32'(bus.disp_ready), 32'd1);
        check("rst_issue_valid", 32'(bus.issue_valid), 32'd0);
        check("rst_issue_op", 32'(bus.issue_op), 32'd0);
        check("rst_issue_a", bus.issue_a, 32'd0);
        check("rst_issue_b", bus.issue_b, 32'd0);
        check("rst_issue_dest", 32'(bus.issue_dest), 32'd0);
        #9 rst_n = 1'b1;
        tick();

        // Both operands present: issue one cycle after dispatch.
        set_disp(ALU_ADD, 32'd5, 4'd0, 32'd7, 4'd0, 4'd3);
        tick();
        bus.disp_valid = 1'b0;
        check("add_issue_valid", 32'(bus.issue_valid), 32'd1);
        check("add_issue_op", 32'(bus.issue_op), 32'(ALU_ADD));
        check("add_issue_a", bus.issue_a, 32'd5);
        check("add_issue_b", bus.issue_b, 32'd7);
        check("add_issue_dest", 32'(bus.issue_dest), 32'd3);
        bus.issue_ready = 1'b1;
        tick();
        bus.issue_ready = 1'b0;
        check("add_drained", 32'(bus.issue_valid), 32'd0);

        // Pending A woken by a later broadcast.
        set_disp(ALU_SUB, 32'hdead, 4'd2, 32'd1, 4'd0, 4'd4);
        tick();
        bus.disp_valid = 1'b0;
        check("wake_pending0", 32'(bus.issue_valid), 32'd0);
        tick();
        check("wake_pending1", 32'(bus.issue_valid), 32'd0);
        set_cdb(1'b1, 4'd2, 32'h10);
        tick();
        set_cdb(1'b0, 4'd0, 32'd0);
        check("wake_issue_valid", 32'(bus.issue_valid), 32'd1);
        check("wake_issue_a", bus.issue_a, 32'h10);
        check("wake_issue_b", bus.issue_b, 32'd1);
        check("wake_issue_dest", 32'(bus.issue_dest), 32'd4);
        bus.issue_ready = 1'b1;
        tick();
        bus.issue_ready = 1'b0;
        check("wake_drained", 32'(bus.issue_valid), 32'd0);

        // Dispatch bypass from the same-cycle broadcast.
        set_disp(ALU_AND, 32'hbeef, 4'd6, 32'd2, 4'd0, 4'd5);
        set_cdb(1'b1, 4'd6, 32'd9);
        tick();
        bus.disp_valid = 1'b0;
        set_cdb(1'b0, 4'd0, 32'd0);
        check("byp_issue_valid", 32'(bus.issue_valid), 32'd1);
        check("byp_issue_a", bus.issue_a, 32'd9);
        check("byp_issue_dest", 32'(bus.issue_dest), 32'd5);
        bus.issue_ready = 1'b1;
        tick();
        bus.issue_ready = 1'b0;

        // Fill all four entries waiting on tag 5 for both operands.
        for (int i = 0; i < 4; i++) begin
            set_disp(ALU_OR, 32'd0, 4'd5, 32'd0, 4'd5, 4'(i + 1));
            tick();
        end
        bus.disp_valid = 1'b0;
        check("full_disp_ready", 32'(bus.disp_ready), 32'd0);
        check("full_issue_valid", 32'(bus.issue_valid), 32'd0);
        set_disp(ALU_XOR, 32'd1, 4'd0, 32'd2, 4'd0, 4'd9);
        tick();
        bus.disp_valid = 1'b0;
        check("full_ignored_ready", 32'(bus.disp_ready), 32'd0);
        check("full_ignored_valid", 32'(bus.issue_valid), 32'd0);
        set_cdb(1'b1, 4'd5, 32'h55);
        tick();
        set_cdb(1'b0, 4'd0, 32'd0);
        check("order0_dest", 32'(bus.issue_dest), 32'd1);
        check("order0_a", bus.issue_a, 32'h55);
        check("order0_b", bus.issue_b, 32'h55);
        check("order0_disp_ready", 32'(bus.disp_ready), 32'd0);
        bus.issue_ready = 1'b1;
        tick();
        check("order1_dest", 32'(bus.issue_dest), 32'd2);
        check("order1_disp_ready", 32'(bus.disp_ready), 32'd1);
        tick();
        check("order2_dest", 32'(bus.issue_dest), 32'd3);
        tick();
        check("order3_dest", 32'(bus.issue_dest), 32'd4);
        check("order3_valid", 32'(bus.issue_valid), 32'd1);
        tick();
        bus.issue_ready = 1'b0;
        check("order_empty", 32'(bus.issue_valid), 32'd0);

        // Two ready entries stalled: output holds on entry 0.
        set_disp(ALU_SLL, 32'h11, 4'd0, 32'h22, 4'd0, 4'd6);
        tick();
        set_disp(ALU_SRL, 32'h33, 4'd0, 32'h44, 4'd0, 4'd7);
        tick();
        bus.disp_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("stall_valid", 32'(bus.issue_valid), 32'd1);
            check("stall_dest", 32'(bus.issue_dest), 32'd6);
            check("stall_a", bus.issue_a, 32'h11);
            tick();
        end
        // Flush also overrides a same-cycle dispatch.
        flush = 1'b1;
        set_disp(ALU_ADD, 32'd1, 4'd0, 32'd1, 4'd0, 4'd8);
        tick();
        flush = 1'b0;
        bus.disp_valid = 1'b0;
        check("flush_issue_valid", 32'(bus.issue_valid), 32'd0);
        check("flush_disp_ready", 32'(bus.disp_ready), 32'd1);
        check("flush_issue_dest", 32'(bus.issue_dest), 32'd0);

        // Asynchronous reset between edges with entries busy.
        set_disp(ALU_SLT, 32'h1, 4'd0, 32'h2, 4'd0, 4'd10);
        tick();
        set_disp(ALU_SLTU, 32'h3, 4'd0, 32'h4, 4'd0, 4'd11);
        tick();
        bus.disp_valid = 1'b0;
        check("pre_rst_valid", 32'(bus.issue_valid), 32'd1);
        check("pre_rst_dest", 32'(bus.issue_dest), 32'd10);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(bus.issue_valid), 32'd0);
        check("async_rst_disp_ready", 32'(bus.disp_ready), 32'd1);
        check("async_rst_dest", 32'(bus.issue_dest), 32'd0);
        #1 rst_n = 1'b1;
        tick();
        check("post_rst_valid", 32'(bus.issue_valid), 32'd0);

        // Normal operation resumes after reset.
        set_disp(ALU_XOR, 32'h77, 4'd0, 32'h88, 4'd0, 4'd12);
        tick();
        bus.disp_valid = 1'b0;
        check("resume_valid", 32'(bus.issue_valid), 32'd1);
        check("resume_b", bus.issue_b, 32'h88);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Tomasulo reservation station directly downstream of the operand A/B managers.
- Buffers dispatched ops with each operand either as a value or as a pending ROB tag.
- Snoops the common data bus (CDB) to wake up pending operands.
- Issues ready ops to the execute unit through a valid/ready handshake.

Parameters:
- DEPTH, 4, number of entries (2..16).
- ROB_W, `ROB_ENTRY_WIDTH, ROB tag width.
- OP_W, 4, ALU op code width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous squash of all entries (mispredict/exception).
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  at least one free entry (from registered state).
- disp_op  in  OP_W  ALU op.
- disp_a_value  in  32  operand A value; meaningful when disp_a_tag==0.
- disp_a_tag  in  ROB_W  operand A producer tag; 0 = value present.
- disp_b_value  in  32  operand B value.
- disp_b_tag  in  ROB_W  operand B producer tag; 0 = value present.
- disp_dest  in  ROB_W  ROB index of this op's result.
- cdb_valid  in  1  CDB broadcast this cycle.
- cdb_tag  in  ROB_W  broadcasting ROB index (never 0).
- cdb_value  in  32  broadcast result.
- issue_valid  out  1  an entry with both operands present exists.
- issue_ready  in  1  execute unit accepts.
- issue_op  out  OP_W  selected entry op.
- issue_a  out  32  selected operand A value.
- issue_b  out  32  selected operand B value.
- issue_dest  out  ROB_W  selected entry dest.

Behaviour:
- ROB index 0 is reserved and never allocated. A tag of 0 means the operand value is held.
- Entry state per slot: busy, op, a_tag, a_val, b_tag, b_val, dest.
- Reset (async, rst_n=0): all busy=0, all fields 0.
  - Outputs: disp_ready=1, issue_valid=0, issue_op/a/b/dest=0.
- Dispatch:
  - On disp_valid && disp_ready, write the lowest-index non-busy entry and set busy=1.
  - disp_ready = !(all busy) from registered state. An entry freed by issue in the same cycle is not reusable until the next cycle.
  - disp_valid while disp_ready=0: ignored, no state change.
- Wake-up:
  - Each cycle with cdb_valid, every busy entry whose a_tag==cdb_tag loads a_val=cdb_value and sets a_tag=0. Same for B.
  - Dispatch bypass: if a dispatched operand tag equals cdb_tag in the same cycle, store cdb_value and tag 0 directly.
  - Both operands may match one broadcast.
- Issue (combinational select from registered state):
  - An entry is ready when busy && a_tag==0 && b_tag==0.
  - issue_valid = any ready entry. issue_* come from the lowest-index ready entry, and are 0 when none is ready.
  - On issue_valid && issue_ready, that entry's busy is cleared at the clock edge.
  - issue_* must hold stable while issue_valid && !issue_ready, except when a lower-index entry becomes ready. The execute unit accepts any presented op, so this is permitted.
- Latency:
  - Operand present at dispatch: issue_valid rises the cycle after dispatch.
  - CDB wake-up: issue_valid rises the cycle after the broadcast.
- Full and empty:
  - With DEPTH entries busy, disp_ready=0.
  - With none busy, issue_valid=0.
- Flush:
  - Clears all busy next edge and overrides same-cycle dispatch, issue and wake-up.
  - issue_valid stays combinational during the flush cycle, but the downstream stage ignores it under flush.
- Reset mid-operation: all entries discarded immediately, without waiting for a clock.

Decomposition:
- Shared package/defines.vh holds ROB_ENTRY_WIDTH (existing), ALU op encodings, and RS_TAG_NONE = 0.
- One natural sub-module, rs_priority_encoder: lowest-set-bit index plus any flag, DEPTH wide. Instantiate twice, for free-slot allocation and ready-entry selection.

Test Plan:
- Reset, then dispatch op=ADD, a=5/tag0, b=7/tag0, dest=3 -> next cycle issue_valid=1, issue_a=5, issue_b=7, issue_dest=3; with issue_ready=1, issue_valid=0 the following cycle.
- Dispatch a_tag=2, b=1/tag0; later cdb_valid, tag=2, value=0x10 -> issue_valid rises next cycle with issue_a=0x10.
- Dispatch a_tag=6 in the same cycle as cdb tag=6, value=9 -> entry stored ready; issue_a=9 next cycle.
- Fill all 4 entries with tag=5 operands -> disp_ready=0 and a 5th dispatch is ignored. Broadcast tag 5 -> 4 issues in index order 0,1,2,3 with issue_ready held 1; disp_ready=1 after the first issue edge.
- Two entries ready, issue_ready=0 for 3 cycles -> issue_* stable on entry 0. flush=1 -> issue_valid=0 and disp_ready=1 next cycle.
- Assert rst_n=0 asynchronously between edges with entries busy -> issue_valid drops immediately and disp_ready=1.
